// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter multiplexing NR_MASTERS TCDM requesters onto one slave port.
// A fixed 1-cycle response is routed back to the master that won the handshake.
module tcdm_rr_arbiter #(
  parameter int NR_MASTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int IDX_WIDTH = $clog2(NR_MASTERS)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NR_MASTERS-1:0]                  m_req_i,
  input  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0]  m_add_i,
  input  logic [NR_MASTERS-1:0]                  m_wen_i,
  input  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
  input  logic [NR_MASTERS-1:0][BE_WIDTH-1:0]    m_be_i,
  output logic [NR_MASTERS-1:0]                  m_gnt_o,
  output logic [NR_MASTERS-1:0]                  m_r_valid_o,
  output logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]  m_r_rdata_o,
  output logic                                   s_req_o,
  output logic [ADDR_WIDTH-1:0]                  s_add_o,
  output logic                                   s_wen_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  output logic [BE_WIDTH-1:0]                    s_be_o,
  input  logic                                   s_gnt_i,
  input  logic                                   s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  s_r_rdata_i,
  output logic [CNT_WIDTH-1:0]                   stall_cnt_o,
  input  logic                                   stall_clr_i,
  output logic                                   resp_err_o
);

  logic [IDX_WIDTH-1:0] rr_q;
  logic [IDX_WIDTH-1:0] resp_idx_q;
  logic                 pend_q;
  logic [IDX_WIDTH-1:0] sel;
  logic [IDX_WIDTH-1:0] rr_next;
  logic                 handshake;
  logic                 stall;
  logic                 proto_err;

  // Scan from the pointer upward with wrap; the first requester found wins.
  always_comb begin
    logic found;
    int   j;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      j = int'(rr_q) + i;
      if (j >= NR_MASTERS) j = j - NR_MASTERS;
      if (!found && m_req_i[j]) begin
        found = 1'b1;
        sel   = IDX_WIDTH'(j);
      end
    end
  end

  assign s_req_o   = |m_req_i;
  assign s_add_o   = m_add_i[sel];
  assign s_wen_o   = m_wen_i[sel];
  assign s_wdata_o = m_wdata_i[sel];
  assign s_be_o    = m_be_i[sel];

  assign handshake = s_req_o & s_gnt_i;
  assign stall     = s_req_o & ~s_gnt_i;
  assign proto_err = s_r_valid_i ^ pend_q;
  assign rr_next   = (sel == IDX_WIDTH'(NR_MASTERS - 1)) ? '0 : sel + IDX_WIDTH'(1);

  always_comb begin
    m_gnt_o = '0;
    if (s_req_o) m_gnt_o[sel] = s_gnt_i;
  end

  always_comb begin
    m_r_valid_o = '0;
    if (pend_q) m_r_valid_o[resp_idx_q] = s_r_valid_i;
  end

  for (genvar gi = 0; gi < NR_MASTERS; gi++) begin : g_rdata
    assign m_r_rdata_o[gi] = s_r_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      resp_idx_q  <= '0;
      pend_q      <= 1'b0;
      stall_cnt_o <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      if (handshake) begin
        rr_q       <= rr_next;
        resp_idx_q <= sel;
      end
      pend_q <= handshake;
      if (proto_err) resp_err_o <= 1'b1;
      // Clear wins over increment; the counter sticks at all-ones.
      if (stall_clr_i) stall_cnt_o <= '0;
      else if (stall && (stall_cnt_o != {CNT_WIDTH{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Self-checking bench for tcdm_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_tcdm_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [N-1:0]          req;
  logic [N-1:0][AW-1:0]  add;
  logic [N-1:0]          wen;
  logic [N-1:0][DW-1:0]  wdata;
  logic [N-1:0][DW/8-1:0] be;
  logic [N-1:0]          gnt;
  logic [N-1:0]          r_valid;
  logic [N-1:0][DW-1:0]  r_rdata;
  logic                  s_req;
  logic [AW-1:0]         s_add;
  logic                  s_wen;
  logic [DW-1:0]         s_wdata;
  logic [DW/8-1:0]       s_be;
  logic                  s_gnt;
  logic                  s_r_valid;
  logic [DW-1:0]         s_r_rdata;
  logic [CW-1:0]         stall_cnt;
  logic                  stall_clr;
  logic                  resp_err;

  tcdm_rr_arbiter #(.NR_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(req), .m_add_i(add), .m_wen_i(wen), .m_wdata_i(wdata), .m_be_i(be),
    .m_gnt_o(gnt), .m_r_valid_o(r_valid), .m_r_rdata_o(r_rdata),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata),
    .stall_cnt_o(stall_cnt), .stall_clr_i(stall_clr), .resp_err_o(resp_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          md_ptr;
  int          md_idx;
  bit          md_pend;
  bit          md_err;
  int unsigned md_cnt;

  // Values sampled during the last checked cycle
  logic [N-1:0]  smp_gnt;
  logic [N-1:0]  smp_rvalid;
  logic [DW-1:0] smp_rdata2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_sel();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (md_ptr + k) % N;
      if (req[j]) return j;
    end
    return 0;
  endfunction

  // Inputs are already set; check combinational outputs, clock once, update model, check registers.
  task automatic cycle(input bit do_chk);
    int s;
    bit sreq;
    bit hs;
    #1;
    sreq       = |req;
    s          = exp_sel();
    smp_gnt    = gnt;
    smp_rvalid = r_valid;
    smp_rdata2 = r_rdata[2];
    if (do_chk) begin
      chk("s_req", s_req, sreq);
      chk("m_gnt", gnt, (sreq && s_gnt) ? (64'd1 << s) : 64'd0);
      chk("m_r_valid", r_valid, (md_pend && s_r_valid) ? (64'd1 << md_idx) : 64'd0);
      if (sreq) begin
        chk("s_add", s_add, add[s]);
        chk("s_wen", s_wen, wen[s]);
        chk("s_wdata", s_wdata, wdata[s]);
        chk("s_be", s_be, be[s]);
      end
      if (md_pend && s_r_valid) chk("m_r_rdata", r_rdata[md_idx], s_r_rdata);
    end
    @(posedge clk);
    hs = sreq && s_gnt;
    if (s_r_valid != md_pend) md_err = 1'b1;
    if (stall_clr) md_cnt = 0;
    else if (sreq && !s_gnt && md_cnt != 32'hFFFF) md_cnt++;
    if (hs) begin
      md_ptr = (s + 1) % N;
      md_idx = s;
    end
    md_pend = hs;
    #1;
    if (do_chk) begin
      chk("stall_cnt", stall_cnt, md_cnt);
      chk("resp_err", resp_err, md_err);
    end
  endtask

  task automatic zero_inputs();
    req = '0; add = '0; wen = '0; wdata = '0; be = '0;
    s_gnt = 1'b0; s_r_valid = 1'b0; s_r_rdata = '0; stall_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    md_ptr = 0; md_idx = 0; md_pend = 1'b0; md_cnt = 0; md_err = 1'b0;
    s_r_valid = 1'b1;
    #3;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_r_valid", r_valid, 0);
    s_r_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    rst_n = 1'b0;
    zero_inputs();
    #2;
    do_reset();
    cycle(1'b1);

    // All four masters, slave always granting: strict rotation, responses one cycle later.
    req = 4'b1111; s_gnt = 1'b1;
    for (int m = 0; m < N; m++) begin
      add[m] = 32'h1000_0000 + 32'(m * 4); wdata[m] = $urandom; be[m] = 4'hF; wen[m] = m[0];
    end
    for (int k = 0; k < 5; k++) begin
      s_r_valid = md_pend; s_r_rdata = $urandom;
      cycle(1'b1);
      chk("rr_order", smp_gnt, order[k]);
    end
    req = '0; s_r_valid = md_pend; s_r_rdata = $urandom;
    cycle(1'b1);

    // Master 2 read routed back.
    s_r_valid = 1'b0; req = 4'b0100; add[2] = 32'h1C00_0010; wen[2] = 1'b1;
    cycle(1'b1);
    chk("m2_gnt", smp_gnt, 4'b0100);
    req = '0; s_r_valid = 1'b1; s_r_rdata = 32'hDEADBEEF;
    cycle(1'b1);
    chk("m2_rvalid", smp_rvalid, 4'b0100);
    chk("m2_rdata", smp_rdata2, 32'hDEADBEEF);

    // Five stalled cycles, pointer held, then clear.
    s_r_valid = 1'b0; stall_clr = 1'b1;
    cycle(1'b1);
    stall_clr = 1'b0; req = 4'b0011; s_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1);
      chk("stall_no_gnt", smp_gnt, 0);
    end
    chk("stall5", stall_cnt, 5);
    s_gnt = 1'b1;
    cycle(1'b1);
    chk("rr_hold", smp_gnt, 4'b0001);
    req = '0; s_gnt = 1'b0; s_r_valid = 1'b1; stall_clr = 1'b1;
    cycle(1'b1);
    chk("stall_clr", stall_cnt, 0);
    s_r_valid = 1'b0; stall_clr = 1'b0;

    // Randomized well-behaved traffic.
    for (int k = 0; k < 300; k++) begin
      req = N'($urandom);
      s_gnt = ($urandom_range(0, 3) != 0);
      for (int m = 0; m < N; m++) begin
        add[m] = $urandom; wdata[m] = $urandom; be[m] = 4'($urandom); wen[m] = 1'($urandom);
      end
      s_r_valid = md_pend; s_r_rdata = $urandom;
      stall_clr = ($urandom_range(0, 15) == 0);
      cycle(1'b1);
    end

    // Saturation of the stall counter.
    req = '0; s_gnt = 1'b0; s_r_valid = md_pend; stall_clr = 1'b1;
    cycle(1'b1);
    stall_clr = 1'b0; s_r_valid = 1'b0; req = 4'b0001;
    for (int k = 0; k < 65534; k++) cycle(1'b0);
    chk("stall_pre_sat", stall_cnt, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      chk("stall_sat", stall_cnt, 16'hFFFF);
    end

    // Orphan response raises a sticky error.
    req = '0; s_r_valid = 1'b1; s_r_rdata = 32'h1234_5678;
    cycle(1'b1);
    chk("orphan_rvalid", smp_rvalid, 0);
    chk("orphan_err", resp_err, 1);
    s_r_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      chk("err_sticky", resp_err, 1);
    end

    // Reset during a pending read of master 1.
    do_reset();
    req = 4'b0010; wen[1] = 1'b1; add[1] = 32'h0000_0040; s_gnt = 1'b1;
    cycle(1'b1);
    chk("m1_gnt", smp_gnt, 4'b0010);
    do_reset();
    req = 4'b0110; s_gnt = 1'b1; s_r_valid = 1'b0;
    cycle(1'b1);
    chk("post_rst_gnt", smp_gnt, 4'b0010);
    chk("post_rst_no_rvalid", smp_rvalid, 0);
    req = '0; s_r_valid = 1'b1;
    cycle(1'b1);
    chk("post_rst_rvalid", smp_rvalid, 4'b0010);
    s_r_valid = 1'b0;
    cycle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
